// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions: widths, flit type codes, HEAD field offsets
// and the spike packer state encoding.
package noc_flit_pkg;

    localparam int FLIT_W   = 32;
    localparam int CW       = 4;
    localparam int MAX_DEST = 4;
    localparam int TS_W     = 16;

    localparam logic [1:0] FLIT_HEAD = 2'b10;
    localparam logic [1:0] FLIT_BODY = 2'b00;
    localparam logic [1:0] FLIT_TAIL = 2'b01;

    localparam int DST_X_LSB = 26;
    localparam int DST_Y_LSB = 22;
    localparam int SRC_X_LSB = 18;
    localparam int SRC_Y_LSB = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HEAD,
        ST_BODY,
        ST_TAIL
    } packer_state_t;

    // Clamp a requested fan-out to the number of destination slots.
    function automatic logic [2:0] sat_dest(input logic [2:0] n, input int max_dest);
        logic [2:0] lim;
        lim = 3'(max_dest);
        return (n > lim) ? lim : n;
    endfunction

endpackage

// File: rtl/spike_flit_packer_if.sv
// Valid/ready flit stream from the spike packer into the router local port.
interface spike_flit_packer_if #(
    parameter int FLIT_W = 32
);
    logic [FLIT_W-1:0] flit_out;
    logic              flit_valid;
    logic              flit_ready;

    modport master (output flit_out, output flit_valid, input flit_ready);
    modport slave  (input flit_out, input flit_valid, output flit_ready);
endinterface

// File: rtl/spike_ts_counter.sv
// Free-running 16-bit spike timestamp, advanced by one on each step pulse.
module spike_ts_counter
    import noc_flit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            step,
    output logic [TS_W-1:0] ts
);
    logic [TS_W-1:0] ts_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ts_reg <= '0;
        else if (step)
            ts_reg <= ts_reg + 1'b1;
    end

    assign ts = ts_reg;
endmodule

// File: rtl/spike_flit_packer.sv
// Pops spikes from the neuron FIFO and emits one HEAD/TAIL unicast packet per destination.
// Optional SPIKE_TIMESTAMP_EN inserts a BODY{id} flit and carries a timestamp in the TAIL.
module spike_flit_packer
    import noc_flit_pkg::*;
#(
    parameter int DW       = 8,
    parameter int CW       = 4,
    parameter int MAX_DEST = 4,
    parameter int FLIT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DW-1:0]             fifo_dout,
    input  logic                      fifo_empty,
    output logic                      fifo_re,
    input  logic [CW-1:0]             my_x,
    input  logic [CW-1:0]             my_y,
    input  logic [2:0]                dest_num,
    input  logic [MAX_DEST*2*CW-1:0]  dest_xy,
    input  logic                      step,
    spike_flit_packer_if.master       flit_if,
    output logic                      busy,
    output logic [15:0]               sent_cnt,
    output logic [15:0]               drop_cnt
);
    localparam int IDX_W = (MAX_DEST > 1) ? $clog2(MAX_DEST) : 1;

    packer_state_t     state_reg, state_next;
    logic [DW-1:0]     id_reg, id_next;
    logic [2:0]        dn_reg, dn_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [FLIT_W-1:0] flit_reg, flit_next;
    logic              valid_reg, valid_next;
    logic [15:0]       sent_reg, sent_next;
    logic [15:0]       drop_reg, drop_next;

    logic [CW-1:0]     dst_x [MAX_DEST];
    logic [CW-1:0]     dst_y [MAX_DEST];
    logic [IDX_W-1:0]  head_idx;
    logic [FLIT_W-1:0] head_flit;
    logic [FLIT_W-1:0] id_word;
    logic [2:0]        dest_num_sat;
    logic              last_dest;

    generate
        for (genvar gi = 0; gi < MAX_DEST; gi++) begin : g_dest
            assign dst_x[gi] = dest_xy[gi*2*CW+CW +: CW];
            assign dst_y[gi] = dest_xy[gi*2*CW    +: CW];
        end
    endgenerate

    // The HEAD flit is always built for the packet about to start: entry 0
    // when leaving WAIT, otherwise the entry after the one just finished.
    assign head_idx     = (state_reg == ST_WAIT) ? '0 : idx_reg + 1'b1;
    assign dest_num_sat = sat_dest(dest_num, MAX_DEST);
    assign last_dest    = (3'(idx_reg) == dn_reg - 3'd1);

    always_comb begin
        head_flit = '0;
        head_flit[FLIT_W-1 -: 2]   = FLIT_HEAD;
        head_flit[DST_X_LSB +: CW] = dst_x[head_idx];
        head_flit[DST_Y_LSB +: CW] = dst_y[head_idx];
        head_flit[SRC_X_LSB +: CW] = my_x;
        head_flit[SRC_Y_LSB +: CW] = my_y;
        id_word = '0;
        id_word[DW-1:0] = id_reg;
    end

`ifdef SPIKE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
    logic [TS_W-1:0]   ts_snap_reg, ts_snap_next;
    logic [FLIT_W-1:0] ts_word;

    spike_ts_counter u_ts (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .ts   (ts)
    );

    always_comb begin
        ts_word = '0;
        ts_word[TS_W-1:0] = ts_snap_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ts_snap_reg <= '0;
        else
            ts_snap_reg <= ts_snap_next;
    end
`else
    logic unused_step;
    assign unused_step = step;
`endif

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        dn_next    = dn_reg;
        idx_next   = idx_reg;
        flit_next  = flit_reg;
        valid_next = valid_reg;
        sent_next  = sent_reg;
        drop_next  = drop_reg;
`ifdef SPIKE_TIMESTAMP_EN
        ts_snap_next = ts_snap_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty)
                    state_next = ST_WAIT;
            end
            ST_WAIT: begin
                id_next = fifo_dout;
                dn_next = dest_num_sat;
`ifdef SPIKE_TIMESTAMP_EN
                ts_snap_next = ts;
`endif
                if (dest_num_sat == 3'd0) begin
                    drop_next  = drop_reg + 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    idx_next   = '0;
                    flit_next  = head_flit;
                    valid_next = 1'b1;
                    state_next = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (flit_if.flit_ready) begin
`ifdef SPIKE_TIMESTAMP_EN
                    flit_next  = id_word;
                    flit_next[FLIT_W-1 -: 2] = FLIT_BODY;
                    state_next = ST_BODY;
`else
                    flit_next  = id_word;
                    flit_next[FLIT_W-1 -: 2] = FLIT_TAIL;
                    state_next = ST_TAIL;
`endif
                end
            end
`ifdef SPIKE_TIMESTAMP_EN
            ST_BODY: begin
                if (flit_if.flit_ready) begin
                    flit_next  = ts_word;
                    flit_next[FLIT_W-1 -: 2] = FLIT_TAIL;
                    state_next = ST_TAIL;
                end
            end
`endif
            ST_TAIL: begin
                if (flit_if.flit_ready) begin
                    sent_next = sent_reg + 1'b1;
                    if (last_dest) begin
                        flit_next  = '0;
                        valid_next = 1'b0;
                        state_next = ST_IDLE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        flit_next  = head_flit;
                        state_next = ST_HEAD;
                    end
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            id_reg    <= '0;
            dn_reg    <= '0;
            idx_reg   <= '0;
            flit_reg  <= '0;
            valid_reg <= 1'b0;
            sent_reg  <= '0;
            drop_reg  <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
            dn_reg    <= dn_next;
            idx_reg   <= idx_next;
            flit_reg  <= flit_next;
            valid_reg <= valid_next;
            sent_reg  <= sent_next;
            drop_reg  <= drop_next;
        end
    end

    // Pop only from IDLE, so the registered empty flag can never cause an underflow.
    assign fifo_re            = (state_reg == ST_IDLE) && !fifo_empty && !rst;
    assign busy               = (state_reg != ST_IDLE);
    assign flit_if.flit_out   = flit_reg;
    assign flit_if.flit_valid = valid_reg;
    assign sent_cnt           = sent_reg;
    assign drop_cnt           = drop_reg;
endmodule

// File: tb/tb_spike_flit_packer.sv
// Scoreboard bench for spike_flit_packer: FIFO model, expected-flit queue, handshake monitor.
module tb_spike_flit_packer;
    localparam int DW = 8, CW = 4, MAX_DEST = 4, FLIT_W = 32;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [DW-1:0]            fifo_dout = '0;
    logic                     fifo_empty = 1'b1;
    logic                     fifo_re;
    logic [CW-1:0]            my_x, my_y;
    logic [2:0]               dest_num;
    logic [MAX_DEST*2*CW-1:0] dest_xy;
    logic                     step;
    logic                     busy;
    logic [15:0]              sent_cnt, drop_cnt;

    spike_flit_packer_if #(.FLIT_W(FLIT_W)) flit_if ();

    spike_flit_packer #(.DW(DW), .CW(CW), .MAX_DEST(MAX_DEST), .FLIT_W(FLIT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .my_x       (my_x),
        .my_y       (my_y),
        .dest_num   (dest_num),
        .dest_xy    (dest_xy),
        .step       (step),
        .flit_if    (flit_if.master),
        .busy       (busy),
        .sent_cnt   (sent_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]     fifo_q [$];
    logic [FLIT_W-1:0] exp_q [$];
    int                n_checks = 0;
    int                n_fail = 0;
    int                exp_sent = 0;
    int                exp_drop = 0;
    int                re_cnt = 0;
    logic [15:0]       tb_ts = '0;
    logic              held = 1'b0;
    logic [FLIT_W-1:0] held_flit = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // generic_fifo_sc_b read side: data one cycle after re, registered empty flag
    always @(posedge clk) begin
        if (fifo_re && fifo_q.size() > 0)
            fifo_dout <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Mid-cycle monitor: handshakes, hold stability and pop legality
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (fifo_re) begin
                re_cnt++;
                check("re_while_empty", 32'(fifo_empty), 32'd0);
            end
            if (held) begin
                check("hold_valid", 32'(flit_if.flit_valid), 32'd1);
                check("hold_data", flit_if.flit_out, held_flit);
            end
            if (flit_if.flit_valid && flit_if.flit_ready) begin
                held = 1'b0;
                $display("flit accepted 0x%08h at %0t", flit_if.flit_out, $time);
                if (exp_q.size() == 0)
                    check("unexpected_flit", 32'(flit_if.flit_valid), 32'd0);
                else
                    check("flit", flit_if.flit_out, exp_q.pop_front());
            end else if (flit_if.flit_valid) begin
                held      = 1'b1;
                held_flit = flit_if.flit_out;
            end
        end
    end

    task automatic push_spike(input logic [DW-1:0] id);
        int n;
        n = (int'(dest_num) > MAX_DEST) ? MAX_DEST : int'(dest_num);
        if (n == 0) exp_drop++;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({2'b10, dest_xy[i*2*CW+CW +: CW], dest_xy[i*2*CW +: CW], my_x, my_y, 14'b0});
`ifdef SPIKE_TIMESTAMP_EN
            exp_q.push_back({2'b00, 22'b0, id});
            exp_q.push_back({2'b01, 14'b0, tb_ts});
`else
            exp_q.push_back({2'b01, 22'b0, id});
`endif
            exp_sent++;
        end
        fifo_q.push_back(id);
    endtask

    task automatic wait_done(input bit rnd, input string tag);
        int idle = 0;
        int cyc = 0;
        while (idle < 3 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (rnd) flit_if.flit_ready = 1'($urandom_range(0, 1));
            if (fifo_q.size() == 0 && fifo_empty && !busy) idle++;
            else idle = 0;
        end
        flit_if.flit_ready = 1'b1;
        check({tag, "_timeout"}, 32'(idle < 3), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_sent_cnt"}, 32'(sent_cnt), 32'(exp_sent[15:0]));
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop[15:0]));
    endtask

    task automatic wait_valid(input string tag);
        int cyc = 0;
        while (!flit_if.flit_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_valid_timeout"}, 32'(flit_if.flit_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int re0;
        my_x = 4'd1; my_y = 4'd2;
        dest_num = 3'd1; dest_xy = '0; step = 1'b0;
        flit_if.flit_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_flit_out", flit_if.flit_out, 32'd0);
        check("rst_flit_valid", 32'(flit_if.flit_valid), 32'd0);
        check("rst_fifo_re", 32'(fifo_re), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sent", 32'(sent_cnt), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;

        // Single destination
        dest_xy = {8'h00, 8'h00, 8'h00, {4'd3, 4'd5}};
        re0 = re_cnt;
        push_spike(8'hAA);
        wait_done(1'b0, "single");
        check("single_re_pulses", 32'(re_cnt - re0), 32'd1);

        // Three destinations, two spikes
        dest_num = 3'd3;
        dest_xy = {{4'd9, 4'd15}, {4'd6, 4'd7}, {4'd2, 4'd8}, {4'd4, 4'd1}};
        re0 = re_cnt;
        push_spike(8'hBB);
        push_spike(8'hCC);
        wait_done(1'b0, "fanout3");
        check("fanout3_re_pulses", 32'(re_cnt - re0), 32'd2);

        // Zero destinations drops the spike
        dest_num = 3'd0;
        re0 = re_cnt;
        push_spike(8'hDD);
        wait_done(1'b0, "drop");
        check("drop_re_pulses", 32'(re_cnt - re0), 32'd1);

        // Oversized fan-out saturates to MAX_DEST
        dest_num = 3'd7;
        push_spike(8'h5A);
        wait_done(1'b0, "saturate");

        // Random backpressure
        dest_num = 3'd2;
        push_spike(8'h01);
        push_spike(8'h02);
        push_spike(8'h03);
        wait_done(1'b1, "rand_ready");

        // Ready held low for 5 cycles during HEAD
        dest_num = 3'd1;
        dest_xy = {8'h00, 8'h00, 8'h00, {4'd7, 4'd9}};
        flit_if.flit_ready = 1'b0;
        push_spike(8'h33);
        wait_valid("stall");
        repeat (5) begin @(posedge clk); #1; end
        flit_if.flit_ready = 1'b1;
        wait_done(1'b0, "stall");

        // Reset in the middle of a packet
        flit_if.flit_ready = 1'b0;
        push_spike(8'h44);
        wait_valid("midrst");
        flit_if.flit_ready = 1'b1;
        @(posedge clk); #1;
        flit_if.flit_ready = 1'b0;
`ifndef SPIKE_TIMESTAMP_EN
        check("midrst_in_tail", 32'(flit_if.flit_out[31:30]), 32'd1);
`endif
        rst = 1'b1;
        #1;
        check("midrst_flit_out", flit_if.flit_out, 32'd0);
        check("midrst_flit_valid", 32'(flit_if.flit_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sent", 32'(sent_cnt), 32'd0);
        exp_q.delete();
        exp_sent = 0;
        exp_drop = 0;
        tb_ts = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        flit_if.flit_ready = 1'b1;
        push_spike(8'h55);
        wait_done(1'b0, "after_rst");

        // Three step pulses, then a spike (timestamp 3 when enabled)
        repeat (3) begin
            step = 1'b1;
            tb_ts = tb_ts + 1'b1;
            @(posedge clk); #1;
            step = 1'b0;
            @(posedge clk); #1;
        end
        push_spike(8'h11);
        wait_done(1'b0, "timestamp");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
